roic_spi_target: RTL and testbench

ROIC_SPI_TARGET -- requirements
Module: roic_spi_target

---
 rtl/roic_spi_target.sv | 197 +++++++++++++++++++
 tb/tb_roic_spi_target.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/roic_spi_target.sv
// SPI register target for the ROIC control bus: 24-bit frames (8-bit address, 16-bit data).
// Optional serial readback is enabled by defining ROIC_SPI_TARGET_READBACK_EN.
module roic_spi_target #(
  parameter int NUM_REGS    = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    spi_sclk,
  input  logic                    spi_sen,
  input  logic                    spi_sdata,
  output logic                    spi_sdout,
  output logic [16*NUM_REGS-1:0]  regs,
  output logic                    wr_stb,
  output logic [7:0]              wr_addr,
  output logic [15:0]             wr_data,
  output logic                    frame_err
);

  localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] sen_sync;
  logic [SYNC_STAGES-1:0] sdata_sync;
  logic                   sclk_s;
  logic                   sen_s;
  logic                   sdata_s;
  logic                   sclk_prev;
  logic                   sen_prev;
  logic                   sclk_rise;
  logic                   sen_fall;
  logic                   sen_rise;
  logic [1:0]             settle;
  logic                   armed;

  logic [1:0]             state;
  logic [4:0]             cnt;
  logic [23:0]            shreg;
  logic                   overrun;
  logic [15:0]            mem [NUM_REGS];
  logic [7:0]             f_addr;
  logic [15:0]            f_data;
  logic                   read_mode;
  logic                   in_range;
  logic                   wr_ok;
  logic                   commit;

  // Input synchronizers, reset to the idle bus levels
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_sync  <= '0;
      sen_sync   <= '1;
      sdata_sync <= '0;
      sclk_prev  <= 1'b0;
      sen_prev   <= 1'b1;
    end else begin
      sclk_sync  <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
      sen_sync   <= {sen_sync[SYNC_STAGES-2:0], spi_sen};
      sdata_sync <= {sdata_sync[SYNC_STAGES-2:0], spi_sdata};
      sclk_prev  <= sclk_s;
      sen_prev   <= sen_s;
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign sen_s     = sen_sync[SYNC_STAGES-1];
  assign sdata_s   = sdata_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev;
  assign sen_fall  = ~sen_s & sen_prev;
  assign sen_rise  = sen_s & ~sen_prev;

  // A frame interrupted by reset must not be picked up mid-way: frames are
  // only accepted after a real (post-flush) SEN-high sample has been seen.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      settle <= 2'd0;
      armed  <= 1'b0;
    end else if (settle != 2'(SYNC_STAGES)) begin
      settle <= settle + 2'd1;
    end else if (sen_s) begin
      armed <= 1'b1;
    end
  end

  assign f_addr    = shreg[23:16];
  assign f_data    = shreg[15:0];
  assign read_mode = mem[0][1];
  assign in_range  = (int'(f_addr) < NUM_REGS);
  assign wr_ok     = in_range && (!read_mode || (f_addr == 8'h00));
  assign commit    = (state == FULL) && sen_rise && !overrun;

  // Frame FSM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 5'd0;
      shreg     <= 24'd0;
      overrun   <= 1'b0;
      wr_stb    <= 1'b0;
      wr_addr   <= 8'd0;
      wr_data   <= 16'd0;
      frame_err <= 1'b0;
    end else begin
      wr_stb    <= commit;
      frame_err <= 1'b0;
      if (commit) begin
        wr_addr <= f_addr;
        wr_data <= f_data;
      end
      case (state)
        IDLE: begin
          if (armed && sen_fall) begin
            state   <= SHIFT;
            cnt     <= 5'd0;
            shreg   <= 24'd0;
            overrun <= 1'b0;
          end
        end
        SHIFT: begin
          if (sen_rise) begin
            frame_err <= 1'b1;
            state     <= IDLE;
          end else if (sclk_rise) begin
            shreg <= {shreg[22:0], sdata_s};
            cnt   <= cnt + 5'd1;
            if (cnt == 5'd23) state <= FULL;
          end
        end
        FULL: begin
          if (sen_rise) begin
            frame_err <= overrun;
            state     <= IDLE;
          end else if (sclk_rise) begin
            overrun <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Register file
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) mem[i] <= 16'd0;
    end else if (commit && wr_ok) begin
      mem[f_addr[AW-1:0]] <= f_data;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs[16*g +: 16] = mem[g];
  end

`ifdef ROIC_SPI_TARGET_READBACK_EN
  logic        sclk_fall;
  logic [15:0] rd_word;
  logic [15:0] rd_shift;
  logic        sdout_q;

  assign sclk_fall = ~sclk_s & sclk_prev;

  // After 8 bits the address byte sits in shreg[7:0]
  always_comb begin
    rd_word = 16'd0;
    if (int'(shreg[7:0]) < NUM_REGS) rd_word = mem[shreg[AW-1:0]];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_shift <= 16'd0;
      sdout_q  <= 1'b0;
    end else if (state == IDLE) begin
      sdout_q <= 1'b0;
    end else if (sclk_fall) begin
      if (state == SHIFT && cnt == 5'd8) begin
        sdout_q  <= rd_word[15];
        rd_shift <= {rd_word[14:0], 1'b0};
      end else if (state == SHIFT && cnt > 5'd8) begin
        sdout_q  <= rd_shift[15];
        rd_shift <= {rd_shift[14:0], 1'b0};
      end else begin
        sdout_q <= 1'b0;
      end
    end
  end

  assign spi_sdout = sdout_q & read_mode & ~sen_s;
`else
  assign spi_sdout = 1'b0;
`endif

endmodule

// File: tb/tb_roic_spi_target.sv
// Scoreboard bench for roic_spi_target: directed SPI frames, expected commit/error
// events queued at issue time and checked by an independent monitor.
module tb_roic_spi_target;
  localparam int NUM_REGS = 16;
  localparam int HALF     = 60;
  localparam int GAP      = 400;

`ifdef ROIC_SPI_TARGET_READBACK_EN
  localparam logic [15:0] RB_BEEF = 16'hBEEF;
`else
  localparam logic [15:0] RB_BEEF = 16'h0000;
`endif

  logic                   clk = 1'b0;
  logic                   reset = 1'b1;
  logic                   spi_sclk = 1'b0;
  logic                   spi_sen = 1'b1;
  logic                   spi_sdata = 1'b0;
  logic                   spi_sdout;
  logic [16*NUM_REGS-1:0] regs;
  logic                   wr_stb;
  logic [7:0]             wr_addr;
  logic [15:0]            wr_data;
  logic                   frame_err;

  typedef struct {
    bit          err;
    logic [7:0]  addr;
    logic [15:0] data;
  } ev_t;

  ev_t         expq[$];
  ev_t         exp_e;
  logic [15:0] model [NUM_REGS];
  logic [15:0] rb;
  int          vectors = 0;
  int          miscompares = 0;

  always #5 clk = ~clk;

  roic_spi_target #(.NUM_REGS(NUM_REGS), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .spi_sclk  (spi_sclk),
    .spi_sen   (spi_sen),
    .spi_sdata (spi_sdata),
    .spi_sdout (spi_sdout),
    .regs      (regs),
    .wr_stb    (wr_stb),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .frame_err (frame_err)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, expv);
    end
  endtask

  task automatic check_regs(input string name);
    logic [16*NUM_REGS-1:0] flat;
    for (int i = 0; i < NUM_REGS; i++) flat[16*i +: 16] = model[i];
    vectors++;
    if (regs !== flat) begin
      miscompares++;
      $display("FAIL %s: regs got %h, expected %h", name, regs, flat);
    end
  endtask

  task automatic drained(input string name);
    vectors++;
    if (expq.size() != 0) begin
      miscompares++;
      $display("FAIL %s: %0d expected events never seen, expected 0 pending", name, expq.size());
      expq.delete();
    end
  endtask

  task automatic exp_wr(input logic [7:0] a, input logic [15:0] d);
    expq.push_back('{err: 1'b0, addr: a, data: d});
  endtask

  task automatic exp_err();
    expq.push_back('{err: 1'b1, addr: 8'h00, data: 16'h0000});
  endtask

  // Master: data set while SCLK low, readback sampled just before each rising edge
  task automatic send(input logic [31:0] word, input int nbits, input int gap,
                      input int rst_at, output logic [15:0] rbv);
    rbv = 16'h0000;
    spi_sen = 1'b0;
    #(HALF);
    for (int i = 0; i < nbits; i++) begin
      if (i == rst_at) begin
        reset = 1'b1;
        #30;
        reset = 1'b0;
      end
      spi_sdata = word[nbits-1-i];
      #(HALF);
      if (i >= 8 && i < 24) rbv = {rbv[14:0], spi_sdout};
      spi_sclk = 1'b1;
      #(HALF);
      spi_sclk = 1'b0;
    end
    #(HALF);
    spi_sen = 1'b1;
    #(gap);
  endtask

  // Monitor: every wr_stb / frame_err cycle must match the head of the queue
  initial begin
    forever begin
      @(negedge clk);
      if (wr_stb === 1'b1 || frame_err === 1'b1) begin
        vectors++;
        if (expq.size() == 0) begin
          miscompares++;
          $display("FAIL event_unexpected: wr_stb=%b frame_err=%b addr=%h data=%h, expected no event",
                   wr_stb, frame_err, wr_addr, wr_data);
        end else begin
          exp_e = expq.pop_front();
          if (exp_e.err ? (frame_err !== 1'b1 || wr_stb !== 1'b0)
                        : (wr_stb !== 1'b1 || frame_err !== 1'b0 ||
                           wr_addr !== exp_e.addr || wr_data !== exp_e.data)) begin
            miscompares++;
            $display("FAIL event: got wr_stb=%b frame_err=%b addr=%h data=%h, expected err=%b addr=%h data=%h",
                     wr_stb, frame_err, wr_addr, wr_data, exp_e.err, exp_e.addr, exp_e.data);
          end
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < NUM_REGS; i++) model[i] = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    check_regs("reset_regs");
    check("reset_sdout", {15'd0, spi_sdout}, 16'h0000);
    check("reset_wr_stb", {15'd0, wr_stb}, 16'h0000);
    check("reset_wr_addr", {8'd0, wr_addr}, 16'h0000);
    check("reset_wr_data", wr_data, 16'h0000);
    check("reset_frame_err", {15'd0, frame_err}, 16'h0000);
    #2 reset = 1'b0;
    repeat (6) @(posedge clk);
    #3;

    // Plain write
    exp_wr(8'h05, 16'hA5C3); model[5] = 16'hA5C3;
    send(32'h05A5C3, 24, GAP, -1, rb);
    drained("write_05");
    check_regs("regs_after_05");
    check("sdout_normal_mode", rb, 16'h0000);

    // Abort after 13 bits
    exp_err();
    send(32'h031234 >> 11, 13, GAP, -1, rb);
    drained("abort_13");
    check_regs("regs_after_abort");

    exp_wr(8'h04, 16'hBEEF); model[4] = 16'hBEEF;
    send(32'h04BEEF, 24, GAP, -1, rb);
    drained("write_04");

    // READ_MODE on: only address 0 writable
    exp_wr(8'h00, 16'h0002); model[0] = 16'h0002;
    send(32'h000002, 24, GAP, -1, rb);
    drained("set_read_mode");
    exp_wr(8'h07, 16'hFFFF);
    send(32'h07FFFF, 24, GAP, -1, rb);
    drained("write_07_protected");
    check_regs("regs_protected");

    exp_wr(8'h04, 16'h0000);
    send(32'h040000, 24, GAP, -1, rb);
    drained("readback_04");
    check("readback_04_data", rb, RB_BEEF);
    check_regs("regs_after_readback");

    exp_wr(8'h20, 16'h0000);
    send(32'h200000, 24, GAP, -1, rb);
    drained("readback_20");
    check("readback_20_data", rb, 16'h0000);

    exp_wr(8'h00, 16'h0000); model[0] = 16'h0000;
    send(32'h000000, 24, GAP, -1, rb);
    drained("clear_read_mode");
    check_regs("regs_read_mode_clear");

    // Out-of-range address
    exp_wr(8'h20, 16'h1234);
    send(32'h201234, 24, GAP, -1, rb);
    drained("write_20");
    check_regs("regs_after_20");

    // 26-bit overrun frame
    exp_err();
    send((32'h061111 << 2) | 32'h2, 26, GAP, -1, rb);
    drained("overrun_26");
    check_regs("regs_after_overrun");

    // Reset at bit 10: frame discarded, no events
    send(32'h091234, 24, GAP, 10, rb);
    for (int i = 0; i < NUM_REGS; i++) model[i] = 16'h0000;
    drained("reset_mid_frame");
    check_regs("regs_after_mid_reset");
    check("mid_reset_wr_addr", {8'd0, wr_addr}, 16'h0000);
    check("mid_reset_wr_data", wr_data, 16'h0000);

    exp_wr(8'h0A, 16'h0055); model[10] = 16'h0055;
    send(32'h0A0055, 24, GAP, -1, rb);
    drained("write_after_reset");

    // Back-to-back frames, one SCLK period of SEN high between them
    exp_wr(8'h01, 16'h0011); model[1] = 16'h0011;
    exp_wr(8'h02, 16'h0022); model[2] = 16'h0022;
    send(32'h010011, 24, 2*HALF, -1, rb);
    send(32'h020022, 24, GAP, -1, rb);
    drained("back_to_back");
    check_regs("regs_back_to_back");

    repeat (20) @(posedge clk);
    drained("final");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
